// File: rtl/div_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, handshake levels
// and the ALU op codes that ex decodes to reach it.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract the
// divisor, keep or restore, and shift the quotient bit into dvd.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvs always holds, so bit WIDTH of diff is a true borrow flag.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        rem_next = diff[WIDTH-1:0];
        dvd_next = {dvd[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            dvd_next = {dvd[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// returns {remainder, quotient} for HI/LO writeback.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             neg_q;
    logic             neg_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return $unsigned(-s);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dvs      (dvs),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // Datapath registers (rem/dvd/dvs/sign flags) are only meaningful in
    // DivOn and are always loaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        cnt <= '0;
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            dvd   <= magnitude(opdata1_i, signed_div_i);
                            dvs   <= magnitude(opdata2_i, signed_div_i);
                            rem   <= '0;
                            neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                            state <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    // Two cycles here so ready_o shows two edges after accept.
                    if (annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state    <= DivEnd;
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else if (cnt != CNT_W'(WIDTH)) begin
                        rem <= rem_next;
                        dvd <= dvd_next;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state    <= DivEnd;
                        result_o <= {(neg_r ? negate(rem) : rem),
                                     (neg_q ? negate(dvd) : dvd)};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, abort/reset sequences
// and randomized operands checked against an arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 60);
    endtask

    task automatic count_ready(input int cycles, output int hits);
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (ready_o) hits++;
        end
    endtask

    // Caller is at a negedge with the DUT in DivFree.
    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_lat, input string name);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        wait_ready(n);
        check({name, "_lat"}, 64'(n), 64'(exp_lat));
        check({name, "_res"}, result_o, exp);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({name, "_hold_res"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop_rdy"}, 64'(ready_o), 64'd0);
        check({name, "_drop_res"}, result_o, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int hits;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},       33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, 33};
        vecs[3] = '{1'b0, 32'd5,          32'd0,        64'd0,                        2};
        vecs[4] = '{1'b1, 32'h80000000,   32'd0,        64'd0,                        2};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000}, 33};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF}, 33};
        vecs[7] = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3},        33};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0,        32'd1},        33};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                $sformatf("vec%0d", i));

        // Annul at step 10: no result, then a fresh 9/3 completes normally.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul_rdy", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        count_ready(40, hits);
        check("annul_never_ready", 64'(hits), 64'd0);
        @(negedge clk);
        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "after_annul");

        // Annul while in DivByZero also drops the request.
        signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        count_ready(6, hits);
        check("annul_dbz_never_ready", 64'(hits), 64'd0);
        @(negedge clk);

        // annul_i in DivFree blocks accept: latency counts from its release.
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "annul_blocks");

        // annul_i is ignored once the result is held in DivEnd.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        wait_ready(n);
        check("end_annul_lat", 64'(n), 64'd33);
        @(negedge clk);
        annul_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("end_annul_rdy", 64'(ready_o), 64'd1);
        check("end_annul_res", result_o, {32'd2, 32'd14});
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("end_annul_drop", 64'(ready_o), 64'd0);
        @(negedge clk);

        // Synchronous reset in the middle of DivOn.
        signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF00; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy", 64'(ready_o), 64'd0);
        check("midrst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        count_ready(40, hits);
        check("midrst_never_ready", 64'(hits), 64'd0);
        @(negedge clk);
        run(1'b1, 32'hFFFFFF00, 32'd3, ref_div(1'b1, 32'hFFFFFF00, 32'd3), 33, "after_rst");

        // Randomized operands against the reference model.
        for (int i = 0; i < 500; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 17));
                2:       b = -32'($urandom_range(1, 17));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            run(sgn, a, b, ref_div(sgn, a, b), 33, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
